// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

    typedef enum logic [1:0] {
        LOOKUP,
        FILL,
        DELIVER
    } fetch_state_t;

    localparam int          INST_BYTES    = 4;
    localparam int          BYTE_CNT_W    = 2;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_byte_assembler.sv
// Collects byte-serial memory returns into a little-endian instruction word.
module fetch_byte_assembler
    import fetch_pkg::*;
#(
    parameter int N_BYTES = INST_BYTES
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word_next,
    output logic        o_done
);

    logic [BYTE_CNT_W-1:0] r_cnt;
    logic [31:0]           r_word;
    logic [31:0]           w_word_next;

    // The word including the byte arriving this cycle, so the last byte can be used on its own edge.
    always_comb begin
        w_word_next = r_word;
        w_word_next[{r_cnt, 3'b000} +: 8] = i_byte;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_byte_valid) begin
            r_word <= w_word_next;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign o_word_next = w_word_next;
    assign o_done      = i_byte_valid && !i_clear && (r_cnt == BYTE_CNT_W'(N_BYTES - 1));

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch front-end: cache lookup, byte-serial miss fill and decoder handoff.
module inst_fetcher
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          INST_BYTES = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        jump_en,
    input  logic [31:0] jump_pc,
    output logic [31:0] cache_addr,
    input  logic        cache_hit,
    input  logic [31:0] cache_data,
    output logic        cache_upd,
    output logic [31:0] cache_upd_addr,
    output logic [31:0] cache_upd_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_byte,
    input  logic        mem_byte_valid,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_fill_pc;
    logic [31:0]  r_redirect_pc;
    logic         r_redirect_pending;
    logic         r_cache_upd;
    logic [31:0]  r_cache_upd_addr;
    logic [31:0]  r_cache_upd_data;
    logic         r_mem_req;
    logic [31:0]  r_mem_addr;
    logic         r_inst_valid;
    logic [31:0]  r_inst;
    logic [31:0]  r_inst_pc;

    logic         w_slot_free;
    logic         w_fill_start;
    logic         w_byte_en;
    logic         w_fill_done;
    logic [31:0]  w_word_next;
    logic [31:0]  w_jump_target;

    assign w_slot_free   = !r_inst_valid || inst_ready;
    assign w_fill_start  = rdy_in && (r_state == LOOKUP) && !jump_en && !cache_hit;
    assign w_byte_en     = rdy_in && (r_state == FILL) && mem_byte_valid;
    assign w_jump_target = align_pc(jump_pc);

    fetch_byte_assembler #(
        .N_BYTES (INST_BYTES)
    ) u_assembler (
        .i_clk        (clk_in),
        .i_rst_n      (rst_n_in),
        .i_clear      (w_fill_start),
        .i_byte_valid (w_byte_en),
        .i_byte       (mem_byte),
        .o_word_next  (w_word_next),
        .o_done       (w_fill_done)
    );

    // The update strobe is a single-cycle pulse, so it clears even while frozen.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state            <= LOOKUP;
            r_pc               <= RESET_PC;
            r_fill_pc          <= '0;
            r_redirect_pc      <= '0;
            r_redirect_pending <= 1'b0;
            r_cache_upd        <= 1'b0;
            r_cache_upd_addr   <= '0;
            r_cache_upd_data   <= '0;
            r_mem_req          <= 1'b0;
            r_mem_addr         <= '0;
            r_inst_valid       <= 1'b0;
            r_inst             <= '0;
            r_inst_pc          <= '0;
        end else begin
            r_cache_upd <= 1'b0;
            if (rdy_in) begin
                if (r_inst_valid && inst_ready)
                    r_inst_valid <= 1'b0;
                case (r_state)
                    LOOKUP: begin
                        if (jump_en) begin
                            r_pc         <= w_jump_target;
                            r_inst_valid <= 1'b0;
                        end else if (cache_hit) begin
                            if (w_slot_free) begin
                                r_inst       <= cache_data;
                                r_inst_pc    <= r_pc;
                                r_inst_valid <= 1'b1;
                                r_pc         <= r_pc + 32'd4;
                            end
                        end else begin
                            r_fill_pc  <= r_pc;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= r_pc;
                            r_state    <= FILL;
                        end
                    end
                    FILL: begin
                        if (jump_en) begin
                            r_redirect_pending <= 1'b1;
                            r_redirect_pc      <= w_jump_target;
                            r_inst_valid       <= 1'b0;
                        end
                        if (w_fill_done) begin
                            r_cache_upd      <= 1'b1;
                            r_cache_upd_addr <= r_fill_pc;
                            r_cache_upd_data <= w_word_next;
                            r_mem_req        <= 1'b0;
                            // A redirect seen during the fill discards the word but keeps the cache write.
                            if (jump_en || r_redirect_pending) begin
                                r_pc               <= jump_en ? w_jump_target : r_redirect_pc;
                                r_redirect_pending <= 1'b0;
                                r_state            <= LOOKUP;
                            end else begin
                                r_state <= DELIVER;
                            end
                        end else if (w_byte_en) begin
                            r_mem_addr <= r_mem_addr + 32'd1;
                        end
                    end
                    DELIVER: begin
                        if (jump_en) begin
                            r_pc         <= w_jump_target;
                            r_inst_valid <= 1'b0;
                            r_state      <= LOOKUP;
                        end else if (w_slot_free) begin
                            r_inst       <= r_cache_upd_data;
                            r_inst_pc    <= r_fill_pc;
                            r_inst_valid <= 1'b1;
                            r_pc         <= r_fill_pc + 32'd4;
                            r_state      <= LOOKUP;
                        end
                    end
                    default: r_state <= LOOKUP;
                endcase
            end
        end
    end

    assign cache_addr     = r_pc;
    assign cache_upd      = r_cache_upd;
    assign cache_upd_addr = r_cache_upd_addr;
    assign cache_upd_data = r_cache_upd_data;
    assign mem_req        = r_mem_req;
    assign mem_addr       = r_mem_addr;
    assign inst_valid     = r_inst_valid;
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;

endmodule
